mdu_seq_unit: RTL and testbench
===============================

Name: mdu_seq_unit

Overview:
- Parametrised multiply/divide unit for the pipelined MIPS core. Successor to the fixed-latency MDU delay FSM.
- Performs the arithmetic and owns the HI/LO registers.
- Models configurable multi-cycle latency, with separate multiply and divide latencies.
- Supports abort by pipeline flush (exception or interrupt) and provides a one-cycle result-ready pulse. Sits in the E stage; the hazard unit uses o_Busy.

Parameters:
WIDTH, 32, operand and HI/LO width in bits (must be ≥ 2)
MULT_CYCLES, 5, busy cycles for mult/multu (must be ≥ 1)
DIV_CYCLES, 10, busy cycles for div/divu (must be ≥ 1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
i_Start  input  1  E-stage MDU instruction valid this cycle
i_Op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7-10 see Optional Feature, others none
i_A  input  WIDTH  rs operand / mthi-mtlo data
i_B  input  WIDTH  rt operand
i_Flush  input  1  pipeline flush; aborts or suppresses MDU activity
o_Busy  output  1  registered; high while an operation is in flight
o_Ready  output  1  registered one-cycle pulse when HI/LO take a new arithmetic result
o_Hi  output  WIDTH  HI register
o_Lo  output  WIDTH  LO register

Behaviour:
- Reset (async, any time, including mid-operation): o_Busy=0, o_Ready=0, HI=0, LO=0, counter=0, state IDLE. Any in-flight result is discarded.
- States: IDLE, RUN. Down-counter width is $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- Accept condition (IDLE only): i_Start & ~i_Flush & i_Op in {1..4}.
  - At the accepting edge: latch i_A/i_B/i_Op, load counter with MULT_CYCLES or DIV_CYCLES, go to RUN, o_Busy=1.
- RUN: counter decrements each edge.
  - At the edge where counter==1: write HI/LO, go to IDLE, o_Busy=0, o_Ready=1 for exactly one cycle.
  - o_Busy is therefore high for exactly N cycles following the accept edge.
  - The new HI/LO is visible in the same cycle o_Ready is high.
- i_Start while RUN: ignored (the hazard unit stalls; the request is re-presented later).
- i_Flush while RUN: abort at the next edge. o_Busy=0, HI/LO keep their pre-operation values, no o_Ready pulse.
- i_Flush with i_Start in the same cycle: nothing accepted, no write.
- mthi/mtlo:
  - In IDLE with i_Start & ~i_Flush, HI (or LO) = i_A at the next edge. No busy, no o_Ready.
  - In RUN: ignored.
- Arithmetic:
  - mult/multu: the full 2*WIDTH product is signed or unsigned; HI = upper half, LO = lower half.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Divide by zero: the full busy time is still spent and o_Ready still pulses; HI/LO are left unchanged.
  - Signed overflow case (most-negative / -1): LO = most-negative, HI = 0.
- Unknown i_Op values: treated as none; no state change.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: ops 7 madd, 8 maddu, 9 msub, 10 msubu are accepted like multiply and use MULT_CYCLES.
  - At completion, {HI,LO} = {HI,LO} ± product (signed or unsigned), mod 2^(2*WIDTH), using HI/LO as they stand at completion.
- Undefined: ops 7-10 are treated as none; no logic is generated for them.

Test Plan:
- mult A=0xFFFFFFFD (-3), B=7 accepted at edge 0 -> o_Busy high in cycles 1-5; at edge 5 HI=0xFFFFFFFF, LO=0xFFFFFFEB, o_Ready high for 1 cycle only.
- divu A=0xFFFFFFFF, B=16 -> 10 busy cycles, then LO=0x0FFFFFFF, HI=0x0000000F. div A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- mthi 0x1234, mtlo 0x5678, then mult 2*3 with i_Flush asserted in busy cycle 3 -> o_Busy low next cycle, HI=0x1234, LO=0x5678, no o_Ready.
- div by 0 with HI/LO = 0xAA/0xBB -> 10 busy cycles, o_Ready pulses, HI/LO remain 0xAA/0xBB. Start plus flush in the same cycle -> o_Busy stays 0.
- Start div, assert reset in busy cycle 4 -> all outputs 0 immediately. mtlo issued while busy -> LO unchanged. New mult right after o_Ready -> accepted.
- With MDU_MADD_EN: HI:LO = 0:0xFFFFFFFF, maddu 1*1 -> HI=1, LO=0. Without the macro, op 7 -> no busy, no change.

Source files
------------

// File: rtl/mdu_seq_unit.sv
// Sequential multiply/divide unit that owns HI/LO and models separate mult/div latencies.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are built when MDU_MADD_EN is defined.
module mdu_seq_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_Start,
    input  logic [3:0]       i_Op,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_Flush,
    output logic             o_Busy,
    output logic             o_Ready,
    output logic [WIDTH-1:0] o_Hi,
    output logic [WIDTH-1:0] o_Lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               accept;
    logic [2*WIDTH-1:0] prod, quot_rem;

    function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == OP_MULT) || (op == OP_MULTU) || (op >= OP_MADD && op <= OP_MSUBU);
`else
        return (op == OP_MULT) || (op == OP_MULTU);
`endif
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
`else
        return (op == OP_MULT) || (op == OP_DIV);
`endif
    endfunction

    function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic             sgn);
        logic signed [2*WIDTH-1:0] ext_a, ext_b;
        ext_a = {{WIDTH{sgn & a[WIDTH-1]}}, a};
        ext_b = {{WIDTH{sgn & b[WIDTH-1]}}, b};
        return ext_a * ext_b;
    endfunction

    // Magnitude divide then re-sign: quotient truncates toward zero, remainder follows the
    // dividend, and most-negative / -1 wraps back to most-negative with a zero remainder.
    function automatic logic [2*WIDTH-1:0] div_full(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic             sgn);
        logic             neg_a, neg_b;
        logic [WIDTH-1:0] mag_a, mag_b, quo, rem;
        neg_a = sgn & a[WIDTH-1];
        neg_b = sgn & b[WIDTH-1];
        mag_a = neg_a ? (~a + 1'b1) : a;
        mag_b = neg_b ? (~b + 1'b1) : b;
        if (mag_b == '0) begin
            quo = '0;
            rem = '0;
        end else begin
            quo = mag_a / mag_b;
            rem = mag_a % mag_b;
        end
        if (neg_a ^ neg_b) quo = ~quo + 1'b1;
        if (neg_a)         rem = ~rem + 1'b1;
        return {rem, quo};
    endfunction

    assign prod     = mul_full(a_q, b_q, is_signed_op(op_q));
    assign quot_rem = div_full(a_q, b_q, is_signed_op(op_q));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = 1'b0;
        ready_d = 1'b0;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_Start && !i_Flush) begin
                    if (is_mul_op(i_Op) || is_div_op(i_Op)) begin
                        accept  = 1'b1;
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                        cnt_d   = is_div_op(i_Op) ? DIV_LOAD : MULT_LOAD;
                    end else if (i_Op == OP_MTHI) begin
                        hi_d = i_A;
                    end else if (i_Op == OP_MTLO) begin
                        lo_d = i_A;
                    end
                end
            end
            S_RUN: begin
                if (i_Flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    if (is_div_op(op_q)) begin
                        if (b_q != '0) {hi_d, lo_d} = quot_rem;
`ifdef MDU_MADD_EN
                    end else if (op_q == OP_MADD || op_q == OP_MADDU) begin
                        {hi_d, lo_d} = {hi_q, lo_q} + prod;
                    end else if (op_q == OP_MSUB || op_q == OP_MSUBU) begin
                        {hi_d, lo_d} = {hi_q, lo_q} - prod;
`endif
                    end else begin
                        {hi_d, lo_d} = prod;
                    end
                end else begin
                    cnt_d  = cnt_q - CNT_ONE;
                    busy_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    // Operand latches are pure data and only load on an accepted request.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= i_Op;
            a_q  <= i_A;
            b_q  <= i_B;
        end
    end

    assign o_Busy  = busy_q;
    assign o_Ready = ready_q;
    assign o_Hi    = hi_q;
    assign o_Lo    = lo_q;

endmodule

// File: tb/tb_mdu_seq_unit.sv
// Randomized bench for mdu_seq_unit against a transaction-level HI/LO model.
module tb_mdu_seq_unit;
    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         i_Start = 1'b0;
    logic [3:0]   i_Op = 4'd0;
    logic [W-1:0] i_A = '0;
    logic [W-1:0] i_B = '0;
    logic         i_Flush = 1'b0;
    logic         o_Busy, o_Ready;
    logic [W-1:0] o_Hi, o_Lo;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [31:0]  m_hi = '0;
    logic [31:0]  m_lo = '0;
    logic [3:0]   arith_ops[$];
    logic [3:0]   none_ops[$];

    always #5 clk = ~clk;

    mdu_seq_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .i_Start(i_Start), .i_Op(i_Op), .i_A(i_A), .i_B(i_B),
        .i_Flush(i_Flush), .o_Busy(o_Busy), .o_Ready(o_Ready), .o_Hi(o_Hi), .o_Lo(o_Lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int op_cycles(input logic [3:0] op);
        return (op == 4'd3 || op == 4'd4) ? DC : MC;
    endfunction

    // Reference: plain 64-bit integer arithmetic on the architectural HI/LO pair.
    function automatic void model_arith(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] hi, input logic [31:0] lo,
                                        output logic [31:0] nh, output logic [31:0] nl);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     res, acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        acc = {hi, lo};
        res = acc;
        case (op)
            4'd1: res = 64'(sa * sb);
            4'd2: res = ua * ub;
            4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
            4'd4: if (b != 0) res = {32'(ua % ub), 32'(ua / ub)};
            4'd7: res = acc + 64'(sa * sb);
            4'd8: res = acc + ua * ub;
            4'd9: res = acc - 64'(sa * sb);
            4'd10: res = acc - ua * ub;
            default: res = acc;
        endcase
        nh = res[63:32];
        nl = res[31:0];
    endfunction

    // Starts at a negedge, ends at the negedge of the ready (or abort) cycle.
    task automatic run_arith(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input int flush_at, input bit noise);
        logic [31:0] h0, l0, eh, el;
        int          n;
        h0 = m_hi;
        l0 = m_lo;
        n  = op_cycles(op);
        i_Start = 1'b1; i_Op = op; i_A = a; i_B = b; i_Flush = 1'b0;
        @(negedge clk);
        i_Start = 1'b0; i_Op = 4'd0;
        for (int k = 1; k <= n; k++) begin
            chk("busy_run", o_Busy, 1);
            chk("ready_run", o_Ready, 0);
            chk("hi_hold", o_Hi, h0);
            chk("lo_hold", o_Lo, l0);
            if (noise) begin
                i_Start = 1'($urandom_range(0, 1));
                i_Op    = 4'($urandom_range(1, 6));
                i_A     = $urandom;
                i_B     = $urandom;
            end
            if (k == flush_at) begin
                i_Flush = 1'b1;
                @(negedge clk);
                i_Flush = 1'b0; i_Start = 1'b0;
                chk("busy_abort", o_Busy, 0);
                chk("ready_abort", o_Ready, 0);
                chk("hi_abort", o_Hi, h0);
                chk("lo_abort", o_Lo, l0);
                return;
            end
            @(negedge clk);
        end
        i_Start = 1'b0;
        model_arith(op, a, b, h0, l0, eh, el);
        m_hi = eh;
        m_lo = el;
        chk("busy_done", o_Busy, 0);
        chk("ready_done", o_Ready, 1);
        chk("hi_result", o_Hi, m_hi);
        chk("lo_result", o_Lo, m_lo);
    endtask

    // Single-cycle request: mthi/mtlo, unknown ops, or anything issued together with flush.
    task automatic run_simple(input logic [3:0] op, input logic [31:0] a, input bit flush);
        i_Start = 1'b1; i_Op = op; i_A = a; i_B = $urandom; i_Flush = flush;
        @(negedge clk);
        i_Start = 1'b0; i_Op = 4'd0; i_Flush = 1'b0;
        if (!flush && op == 4'd5) m_hi = a;
        if (!flush && op == 4'd6) m_lo = a;
        chk("busy_simple", o_Busy, 0);
        chk("ready_simple", o_Ready, 0);
        chk("hi_simple", o_Hi, m_hi);
        chk("lo_simple", o_Lo, m_lo);
    endtask

    task automatic run_reset_mid_div();
        i_Start = 1'b1; i_Op = 4'd3; i_A = 32'd100; i_B = 32'd7;
        @(negedge clk);
        i_Start = 1'b0; i_Op = 4'd0;
        repeat (3) @(negedge clk);
        chk("busy_before_reset", o_Busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("busy_reset", o_Busy, 0);
        chk("ready_reset", o_Ready, 0);
        chk("hi_reset", o_Hi, 0);
        chk("lo_reset", o_Lo, 0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 9))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] op;
        int         sel, fl;
        arith_ops = '{4'd1, 4'd2, 4'd3, 4'd4};
        none_ops  = '{4'd0, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
`ifdef MDU_MADD_EN
        arith_ops.push_back(4'd7); arith_ops.push_back(4'd8);
        arith_ops.push_back(4'd9); arith_ops.push_back(4'd10);
`else
        none_ops.push_back(4'd7); none_ops.push_back(4'd8);
        none_ops.push_back(4'd9); none_ops.push_back(4'd10);
`endif
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", o_Busy, 0);
        chk("rst_ready", o_Ready, 0);
        chk("rst_hi", o_Hi, 0);
        chk("rst_lo", o_Lo, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_arith(4'd1, 32'hFFFF_FFFD, 32'd7, 0, 0);
        chk("mult_neg_hi", o_Hi, 32'hFFFF_FFFF);
        chk("mult_neg_lo", o_Lo, 32'hFFFF_FFEB);
        run_arith(4'd4, 32'hFFFF_FFFF, 32'd16, 0, 0);
        chk("divu_hi", o_Hi, 32'h0000_000F);
        chk("divu_lo", o_Lo, 32'h0FFF_FFFF);
        run_arith(4'd3, 32'hFFFF_FFF9, 32'd2, 0, 0);
        chk("div_neg_hi", o_Hi, 32'hFFFF_FFFF);
        chk("div_neg_lo", o_Lo, 32'hFFFF_FFFD);

        run_simple(4'd5, 32'h1234, 0);
        run_simple(4'd6, 32'h5678, 0);
        run_arith(4'd1, 32'd2, 32'd3, 3, 0);
        chk("flush_hi", o_Hi, 32'h1234);
        chk("flush_lo", o_Lo, 32'h5678);

        run_simple(4'd5, 32'hAA, 0);
        run_simple(4'd6, 32'hBB, 0);
        run_arith(4'd3, 32'd5, 32'd0, 0, 0);
        chk("div0_hi", o_Hi, 32'hAA);
        chk("div0_lo", o_Lo, 32'hBB);
        run_simple(4'd3, 32'd5, 1);

        run_arith(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        chk("ovf_hi", o_Hi, 32'd0);
        chk("ovf_lo", o_Lo, 32'h8000_0000);

        run_reset_mid_div();
        run_arith(4'd2, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1);
        run_arith(4'd1, 32'h0000_0011, 32'hFFFF_FFFF, 0, 1);

        run_simple(4'd5, 32'd0, 0);
        run_simple(4'd6, 32'hFFFF_FFFF, 0);
`ifdef MDU_MADD_EN
        run_arith(4'd8, 32'd1, 32'd1, 0, 0);
        chk("maddu_hi", o_Hi, 32'd1);
        chk("maddu_lo", o_Lo, 32'd0);
`else
        run_simple(4'd7, 32'd1, 0);
        chk("op7_hi", o_Hi, 32'd0);
        chk("op7_lo", o_Lo, 32'hFFFF_FFFF);
`endif

        for (int it = 0; it < 150; it++) begin
            sel = $urandom_range(0, 13);
            if (sel <= 7) begin
                op = arith_ops[$urandom_range(0, arith_ops.size() - 1)];
                fl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, op_cycles(op)) : 0;
                run_arith(op, rand_operand(), rand_operand(), fl, 1'($urandom_range(0, 1)));
            end else if (sel <= 9) begin
                run_simple((sel == 8) ? 4'd5 : 4'd6, $urandom, 0);
            end else if (sel == 10) begin
                run_simple(none_ops[$urandom_range(0, none_ops.size() - 1)], $urandom, 0);
            end else if (sel == 11) begin
                run_simple(arith_ops[$urandom_range(0, arith_ops.size() - 1)], $urandom, 1);
            end else begin
                run_simple(4'd0, $urandom, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
